// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding and default register-address width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_hazard_ctrl_pkg;

   localparam int REG_ADDR_W_DEFAULT = 5;
   localparam int MD_CNT_W           = 4;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      MD_BUSY    = 2'd1,
      FETCH_WAIT = 2'd2
   } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Purpose: flags a load in EX whose destination is read by the instruction in ID.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the result feeds the hazard FSM stall decision.
// Ports: idRs1/idRs2 + idUsesRs1/idUsesRs2 (ID sources), exMemRead/exRd (EX load), loadUse (out).
module pipeline_hazard_ctrl_load_use_detect
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
   input  logic [REG_ADDR_W-1:0] idRs1,
   input  logic [REG_ADDR_W-1:0] idRs2,
   input  logic                  idUsesRs1,
   input  logic                  idUsesRs2,
   input  logic                  exMemRead,
   input  logic [REG_ADDR_W-1:0] exRd,
   output logic                  loadUse
);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign loadUse = exMemRead && (exRd != '0) &&
                    ((idUsesRs1 && (idRs1 == exRd)) || (idUsesRs2 && (idRs2 == exRd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: pipeline hazard control - freeze/flush/hold for load-use, branch, mul/div and fetch stalls.
// Latency: 0 cycles; all outputs are combinational from current state and inputs.
// Backpressure: pcFreeze/ifidFreeze/exHold stall upstream stages; flushes insert bubbles.
// Ports: clk, rstn; ID sources, EX load/branch/muldiv info, imemReady in;
//        pcFreeze, ifidFreeze, ifidFlush, idexFlush, exHold, mdBusy out.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MD_LATENCY = 4,
   parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [REG_ADDR_W-1:0] idRs1,
   input  logic [REG_ADDR_W-1:0] idRs2,
   input  logic                  idUsesRs1,
   input  logic                  idUsesRs2,
   input  logic                  exMemRead,
   input  logic [REG_ADDR_W-1:0] exRd,
   input  logic                  exBranchTaken,
   input  logic                  exMdStart,
   input  logic                  imemReady,
   output logic                  pcFreeze,
   output logic                  ifidFreeze,
   output logic                  ifidFlush,
   output logic                  idexFlush,
   output logic                  exHold,
   output logic                  mdBusy
);

   // The start cycle counts as the first busy cycle, so the counter covers the remainder.
   localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

   hazard_state_t         state, stateNxt;
   logic [MD_CNT_W-1:0]   mdCnt, mdCntNxt;
   logic                  pendingRedirect, pendingRedirectNxt;
   logic                  loadUse;
   logic                  frontEndLive;
   logic                  redirect;
   logic                  pcFreezeC, ifidFreezeC, ifidFlushC, idexFlushC, exHoldC, mdBusyC;

   pipeline_hazard_ctrl_load_use_detect #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_load_use_detect (
      .idRs1     (idRs1),
      .idRs2     (idRs2),
      .idUsesRs1 (idUsesRs1),
      .idUsesRs2 (idUsesRs2),
      .exMemRead (exMemRead),
      .exRd      (exRd),
      .loadUse   (loadUse)
   );

   // The cycle a stalled fetch completes is evaluated exactly like a RUN cycle.
   assign frontEndLive = (state == RUN) || ((state == FETCH_WAIT) && imemReady);
   // pendingRedirect is only ever set in FETCH_WAIT, so it is always 0 in RUN.
   assign redirect     = exBranchTaken || pendingRedirect;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state           <= RUN;
         mdCnt           <= '0;
         pendingRedirect <= 1'b0;
      end else begin
         state           <= stateNxt;
         mdCnt           <= mdCntNxt;
         pendingRedirect <= pendingRedirectNxt;
      end
   end

   always_comb begin
      stateNxt           = state;
      mdCntNxt           = mdCnt;
      pendingRedirectNxt = pendingRedirect;
      pcFreezeC          = 1'b0;
      ifidFreezeC        = 1'b0;
      ifidFlushC         = 1'b0;
      idexFlushC         = 1'b0;
      exHoldC            = 1'b0;
      mdBusyC            = 1'b0;

      case (state)
         MD_BUSY: begin
            // Branch and load-use are not evaluated: EX is occupied by the mul/div.
            pcFreezeC   = 1'b1;
            ifidFreezeC = 1'b1;
            exHoldC     = 1'b1;
            mdBusyC     = 1'b1;
            mdCntNxt    = mdCnt - 1'b1;
            if (mdCnt <= 1) begin
               stateNxt = RUN;
            end
         end
         FETCH_WAIT: begin
            if (!imemReady) begin
               // Freeze wins over flush in IF/ID, so a redirect is remembered and
               // applied once the outstanding fetch lands.
               pcFreezeC   = 1'b1;
               ifidFreezeC = 1'b1;
               idexFlushC  = 1'b1;
               if (exBranchTaken) begin
                  pendingRedirectNxt = 1'b1;
               end
            end else begin
               stateNxt           = RUN;
               pendingRedirectNxt = 1'b0;
            end
         end
         default: ;
      endcase

      if (frontEndLive) begin
         if (redirect) begin
            // Fetched word is wrong-path: discard it and bubble ID/EX; nothing frozen.
            ifidFlushC = 1'b1;
            idexFlushC = 1'b1;
         end else if (exMdStart) begin
            pcFreezeC   = 1'b1;
            ifidFreezeC = 1'b1;
            exHoldC     = 1'b1;
            mdBusyC     = 1'b1;
            stateNxt    = MD_BUSY;
            mdCntNxt    = MD_LOAD;
         end else if (loadUse) begin
            pcFreezeC   = 1'b1;
            ifidFreezeC = 1'b1;
            idexFlushC  = 1'b1;
         end else if (!imemReady) begin
            pcFreezeC   = 1'b1;
            ifidFreezeC = 1'b1;
            idexFlushC  = 1'b1;
            stateNxt    = FETCH_WAIT;
         end
      end
   end

   // Outputs are forced low while reset is asserted, independent of the clock.
   assign pcFreeze   = rstn & pcFreezeC;
   assign ifidFreeze = rstn & ifidFreezeC;
   assign ifidFlush  = rstn & ifidFlushC;
   assign idexFlush  = rstn & idexFlushC;
   assign exHold     = rstn & exHoldC;
   assign mdBusy     = rstn & mdBusyC;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Purpose: self-checking bench for pipeline_hazard_ctrl (vector table, directed sequences, random vs model).
// Latency: outputs checked 2 time units after the falling edge, same cycle as stimulus.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

   localparam int MDL = 4;
   localparam int AW  = 5;

   logic          clk = 1'b0;
   logic          rstn;
   logic [AW-1:0] idRs1, idRs2, exRd;
   logic          idUsesRs1, idUsesRs2, exMemRead, exBranchTaken, exMdStart, imemReady;
   logic          pcFreeze, ifidFreeze, ifidFlush, idexFlush, exHold, mdBusy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .MD_LATENCY (MDL),
      .REG_ADDR_W (AW)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .idRs1         (idRs1),
      .idRs2         (idRs2),
      .idUsesRs1     (idUsesRs1),
      .idUsesRs2     (idUsesRs2),
      .exMemRead     (exMemRead),
      .exRd          (exRd),
      .exBranchTaken (exBranchTaken),
      .exMdStart     (exMdStart),
      .imemReady     (imemReady),
      .pcFreeze      (pcFreeze),
      .ifidFreeze    (ifidFreeze),
      .ifidFlush     (ifidFlush),
      .idexFlush     (idexFlush),
      .exHold        (exHold),
      .mdBusy        (mdBusy)
   );

   // Output vector order: {pcFreeze, ifidFreeze, ifidFlush, idexFlush, exHold, mdBusy}
   typedef struct {
      logic          br, md, rdy, mrd;
      logic [AW-1:0] rd, rs1, rs2;
      logic          u1, u2;
   } in_t;

   typedef struct {
      string      name;
      in_t        i;
      logic [5:0] e;
   } vec_t;

   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_STALL = 6'b110100;
   localparam logic [5:0] O_FLUSH = 6'b001100;
   localparam logic [5:0] O_MD    = 6'b110011;

   function automatic in_t mk(logic br, logic md, logic rdy, logic mrd, logic [AW-1:0] rd,
                              logic [AW-1:0] rs1, logic u1, logic [AW-1:0] rs2, logic u2);
      in_t v;
      v.br = br; v.md = md; v.rdy = rdy; v.mrd = mrd;
      v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
      return v;
   endfunction

   task automatic drive(input in_t v);
      exBranchTaken = v.br;  exMdStart = v.md;  imemReady = v.rdy;  exMemRead = v.mrd;
      exRd = v.rd;  idRs1 = v.rs1;  idUsesRs1 = v.u1;  idRs2 = v.rs2;  idUsesRs2 = v.u2;
   endtask

   task automatic chk(input string nm, input logic [5:0] exp);
      logic [5:0] act;
      act = {pcFreeze, ifidFreeze, ifidFlush, idexFlush, exHold, mdBusy};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, sample shortly after.
   task automatic step(input in_t v, input string nm, input logic [5:0] exp);
      @(negedge clk);
      drive(v);
      #2;
      chk(nm, exp);
   endtask

   // Reference model: remaining mul/div cycles, waiting-for-fetch flag, remembered redirect.
   int   mdLeft;
   bit   waiting, pending;

   function automatic logic [5:0] model_out(in_t v);
      logic lu;
      lu = v.mrd && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
      if (mdLeft > 0)                      return O_MD;
      if (waiting && !v.rdy)               return O_STALL;
      if (v.br || (waiting && pending))    return O_FLUSH;
      if (v.md)                            return O_MD;
      if (lu || !v.rdy)                    return O_STALL;
      return O_IDLE;
   endfunction

   task automatic model_clock(input in_t v);
      logic lu;
      lu = v.mrd && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
      if (mdLeft > 0) begin
         mdLeft--;
      end else if (waiting && !v.rdy) begin
         pending = pending | v.br;
      end else begin
         logic redir;
         redir   = v.br || (waiting && pending);
         waiting = 1'b0;
         pending = 1'b0;
         if (!redir) begin
            if (v.md)          mdLeft = MDL - 1;
            else if (!lu && !v.rdy) waiting = 1'b1;
         end
      end
   endtask

   vec_t tbl[$];
   in_t  idle;

   initial begin
      idle = mk(0, 0, 1, 0, 0, 0, 0, 0, 0);

      // Reset: outputs forced low even with hazard-causing inputs present.
      rstn = 1'b0;
      drive(mk(1, 1, 0, 1, 5, 5, 1, 5, 1));
      #2;
      chk("reset_outputs", O_IDLE);
      @(negedge clk);
      rstn = 1'b1;
      drive(idle);
      #2;
      chk("first_cycle_after_reset", O_IDLE);

      // Single-cycle RUN vectors; none of these leave RUN.
      tbl.push_back('{"idle",            mk(0,0,1,0,0,0,0,0,0),  O_IDLE});
      tbl.push_back('{"loaduse_rs2",     mk(0,0,1,1,5,3,1,5,1),  O_STALL});
      tbl.push_back('{"after_loaduse",   mk(0,0,1,0,5,3,1,5,1),  O_IDLE});
      tbl.push_back('{"x0_load",         mk(0,0,1,1,0,0,1,0,0),  O_IDLE});
      tbl.push_back('{"match_not_used",  mk(0,0,1,1,7,7,0,2,0),  O_IDLE});
      tbl.push_back('{"match_not_load",  mk(0,0,1,0,7,7,1,7,1),  O_IDLE});
      tbl.push_back('{"loaduse_rs1",     mk(0,0,1,1,9,9,1,1,1),  O_STALL});
      tbl.push_back('{"branch_loaduse",  mk(1,0,1,1,5,0,0,5,1),  O_FLUSH});
      tbl.push_back('{"branch_md_nordy", mk(1,1,0,0,0,0,0,0,0),  O_FLUSH});
      tbl.push_back('{"branch_only",     mk(1,0,1,0,0,0,0,0,0),  O_FLUSH});
      tbl.push_back('{"idle_end",        mk(0,0,1,0,0,0,0,0,0),  O_IDLE});
      foreach (tbl[k]) step(tbl[k].i, tbl[k].name, tbl[k].e);

      // Mul/div occupancy with a branch injected mid-busy.
      step(mk(0,1,1,0,0,0,0,0,0), "md_c0", O_MD);
      step(idle,                  "md_c1", O_MD);
      step(mk(1,0,1,1,5,5,1,0,0), "md_c2_branch_ignored", O_MD);
      step(idle,                  "md_c3", O_MD);
      step(idle,                  "md_done", O_IDLE);

      // Fetch wait with redirect during the stall.
      step(mk(0,0,0,0,0,0,0,0,0), "fw_c0", O_STALL);
      step(mk(1,0,0,0,0,0,0,0,0), "fw_c1_branch", O_STALL);
      step(mk(0,0,0,0,0,0,0,0,0), "fw_c2", O_STALL);
      step(idle,                  "fw_ready_flush", O_FLUSH);
      step(idle,                  "fw_after", O_IDLE);

      // Reset during MD_BUSY at mdCnt=2.
      step(mk(0,1,1,0,0,0,0,0,0), "rmd_start", O_MD);
      step(idle,                  "rmd_cnt3", O_MD);
      step(idle,                  "rmd_cnt2", O_MD);
      #1 rstn = 1'b0;
      #1 chk("rmd_async_reset", O_IDLE);
      @(negedge clk);
      rstn = 1'b1;
      #2 chk("rmd_released_run", O_IDLE);
      step(idle,                  "rmd_run_next", O_IDLE);

      // A remembered redirect does not survive reset.
      step(mk(0,0,0,0,0,0,0,0,0), "rfw_c0", O_STALL);
      step(mk(1,0,0,0,0,0,0,0,0), "rfw_c1_branch", O_STALL);
      #1 rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      drive(idle);
      #2 chk("rfw_no_flush_after_reset", O_IDLE);

      // Randomized stimulus against the model, starting from a fresh reset.
      @(negedge clk);
      rstn = 1'b0;
      drive(idle);
      @(negedge clk);
      rstn    = 1'b1;
      mdLeft  = 0;
      waiting = 1'b0;
      pending = 1'b0;
      for (int n = 0; n < 600; n++) begin
         in_t        v;
         logic [5:0] exp;
         v = mk(($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 8),
                ($urandom_range(0, 99) < 70), $urandom_range(0, 1) == 1,
                AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
         @(negedge clk);
         drive(v);
         exp = model_out(v);
         #2;
         chk("random", exp);
         model_clock(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MD_LATENCY, default 4: EX-stage multiply/divide occupancy in cycles; legal range 2..15.
REQ-002 Parameter REG_ADDR_W, default 5: register-address width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 idRs1, idRs2  in  REG_ADDR_W each  source registers of the instruction in ID.
REQ-006 idUsesRs1, idUsesRs2  in  1 each  the corresponding source is actually read.
REQ-007 exMemRead  in  1  the instruction in EX is a load.
REQ-008 exRd  in  REG_ADDR_W  destination register of the instruction in EX.
REQ-009 exBranchTaken  in  1  EX resolved a taken branch or jump; single-cycle pulse.
REQ-010 exMdStart  in  1  a multiply/divide entered EX this cycle; single-cycle pulse.
REQ-011 imemReady  in  1  instruction memory returns a valid word this cycle.
REQ-012 pcFreeze  out  1  hold PC.
REQ-013 ifidFreeze  out  1  hold the IF/ID register.
REQ-014 ifidFlush  out  1  clear the IF/ID register.
REQ-015 idexFlush  out  1  insert a bubble into ID/EX.
REQ-016 exHold  out  1  hold EX and the downstream registers.
REQ-017 mdBusy  out  1  a multiply/divide is occupying EX.

Function
REQ-018 FSM states: RUN, MD_BUSY, FETCH_WAIT. A 4-bit down-counter mdCnt and a 1-bit pendingRedirect flag are the only other state.
REQ-019 loadUse = exMemRead and exRd != 0 and ((idUsesRs1 and idRs1 == exRd) or (idUsesRs2 and idRs2 == exRd)).
REQ-020 RUN priority, highest first: exBranchTaken, exMdStart, loadUse, !imemReady.
REQ-021 RUN with exBranchTaken=1: ifidFlush=1 and idexFlush=1, no freeze; stay in RUN; all lower-priority conditions are ignored that cycle.
REQ-022 RUN with exMdStart=1: enter MD_BUSY next cycle with mdCnt=MD_LATENCY-1; pcFreeze, ifidFreeze, exHold and mdBusy are 1 in the same cycle.
REQ-023 RUN with loadUse=1: pcFreeze=1, ifidFreeze=1 and idexFlush=1 for exactly that cycle; stay in RUN.
REQ-024 RUN with imemReady=0: pcFreeze=1, ifidFreeze=1 and idexFlush=1; go to FETCH_WAIT.
REQ-025 MD_BUSY: pcFreeze, ifidFreeze, exHold and mdBusy are 1; mdCnt decrements each cycle; return to RUN on the cycle after mdCnt==1; exBranchTaken and loadUse are ignored.
REQ-026 Total front-end freeze for one multiply/divide is exactly MD_LATENCY cycles, counting the exMdStart cycle.
REQ-027 FETCH_WAIT: pcFreeze=1, ifidFreeze=1 and idexFlush=1 while imemReady=0; exBranchTaken there sets pendingRedirect.
REQ-028 FETCH_WAIT with imemReady=1: go to RUN with outputs as in RUN; if pendingRedirect or exBranchTaken, assert ifidFlush=1 that cycle and clear pendingRedirect.
REQ-029 ifidFlush and ifidFreeze are never 1 in the same cycle, because the IF/ID register gives freeze priority over flush.
REQ-030 Every output is a function of current state and current inputs only, with no additional register stage; the resulting latency is 0 cycles.

Reset
REQ-031 With rstn=0: state is RUN, mdCnt=0, pendingRedirect=0, and all outputs are 0, all applied asynchronously.
REQ-032 Reset asserted during MD_BUSY or FETCH_WAIT abandons the operation; no pending flush survives.
REQ-033 The first cycle after release behaves as RUN.

Structure
REQ-034 The state enum hazard_state_t and the REG_ADDR_W default belong in the shared pipeline package.
REQ-035 One sub-module is natural: load_use_detect, combinational, implementing REQ-019.

Verification
REQ-036 Load-use: exMemRead=1, exRd=5, idRs2=5, idUsesRs2=1 -> exactly one cycle of pcFreeze=ifidFreeze=idexFlush=1.
REQ-037 x0 case: exMemRead=1, exRd=0, idRs1=0, idUsesRs1=1 -> all outputs 0.
REQ-038 Multiply/divide with MD_LATENCY=4: exMdStart pulse -> mdBusy=1 for 4 consecutive cycles, then 0; exBranchTaken injected mid-busy -> no flush.
REQ-039 Fetch wait with redirect: imemReady=0 for 3 cycles with exBranchTaken in cycle 2 -> freeze for 3 cycles, then ifidFlush=1 with ifidFreeze=0 in the cycle imemReady=1.
REQ-040 Simultaneous events: exBranchTaken=1 and loadUse=1 in RUN -> ifidFlush=1, idexFlush=1, pcFreeze=0.
REQ-041 Reset mid-operation: rstn dropped during MD_BUSY at mdCnt=2 -> all outputs 0 immediately; after release, RUN with mdBusy=0.
